// File: rtl/regfile_port_arbiter.sv
// rtl/regfile_port_arbiter.sv - shares register file read/write ports between two issue lanes and two writeback sources
module regfile_port_arbiter #(
    parameter int NUM_REGS = 64,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_a_valid,
    output logic              rd_a_ready,
    input  logic [1:0]        rd_a_en,
    input  logic [ADDR_W-1:0] rd_a_addr0,
    input  logic [ADDR_W-1:0] rd_a_addr1,
    output logic              rd_a_rsp_valid,
    output logic [DATA_W-1:0] rd_a_rsp_data0,
    output logic [DATA_W-1:0] rd_a_rsp_data1,
    input  logic              rd_b_valid,
    output logic              rd_b_ready,
    input  logic [1:0]        rd_b_en,
    input  logic [ADDR_W-1:0] rd_b_addr0,
    input  logic [ADDR_W-1:0] rd_b_addr1,
    output logic              rd_b_rsp_valid,
    output logic [DATA_W-1:0] rd_b_rsp_data0,
    output logic [DATA_W-1:0] rd_b_rsp_data1,
    input  logic              wb_alu_valid,
    output logic              wb_alu_ready,
    input  logic [ADDR_W-1:0] wb_alu_addr,
    input  logic [DATA_W-1:0] wb_alu_data,
    input  logic              wb_mem_valid,
    output logic              wb_mem_ready,
    input  logic [ADDR_W-1:0] wb_mem_addr,
    input  logic [DATA_W-1:0] wb_mem_data,
    output logic [1:0]        rf_read_en,
    output logic [ADDR_W-1:0] rf_raddr_0,
    output logic [ADDR_W-1:0] rf_raddr_1,
    input  logic [DATA_W-1:0] rf_rdata_0,
    input  logic [DATA_W-1:0] rf_rdata_1,
    output logic              rf_write_en,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata
);

    typedef enum logic {LANE_A, LANE_B} lane_e;
    typedef enum logic {SRC_ALU, SRC_MEM} src_e;

    lane_e rd_ptr_q, rd_ptr_d;
    src_e  wr_ptr_q, wr_ptr_d;

    logic              rsp_a_valid_q, rsp_a_valid_d, rsp_b_valid_q, rsp_b_valid_d;
    logic [DATA_W-1:0] rsp_a_data0_q, rsp_a_data0_d, rsp_a_data1_q, rsp_a_data1_d;
    logic [DATA_W-1:0] rsp_b_data0_q, rsp_b_data0_d, rsp_b_data1_q, rsp_b_data1_d;
    logic              wen_q, wen_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        cost_a, cost_b;
    logic              both_fit, gnt_a, gnt_b, gnt_alu, gnt_mem;
    logic [3:0]        op_used, op_port;
    logic [ADDR_W-1:0] op_addr [4];
    logic [DATA_W-1:0] op_data [4];
    logic [DATA_W-1:0] port_data_0, port_data_1;

    // Read grant: both lanes fit in two ports, otherwise the favoured lane wins
    always_comb begin
        cost_a   = 2'(rd_a_en[0]) + 2'(rd_a_en[1]);
        cost_b   = 2'(rd_b_en[0]) + 2'(rd_b_en[1]);
        both_fit = (3'(cost_a) + 3'(cost_b)) <= 3'd2;
        gnt_a    = 1'b0;
        gnt_b    = 1'b0;
        rd_ptr_d = rd_ptr_q;
        if (!reset) begin
            if (rd_a_valid && rd_b_valid && !both_fit) begin
                gnt_a    = (rd_ptr_q == LANE_A);
                gnt_b    = (rd_ptr_q == LANE_B);
                rd_ptr_d = (rd_ptr_q == LANE_A) ? LANE_B : LANE_A;
            end else begin
                gnt_a = rd_a_valid;
                gnt_b = rd_b_valid;
            end
        end
    end

    // Operand packing in order A0, A1, B0, B1; granted sets never exceed two operands
    always_comb begin
        op_used    = {gnt_b & rd_b_en[1], gnt_b & rd_b_en[0], gnt_a & rd_a_en[1], gnt_a & rd_a_en[0]};
        op_addr[0] = rd_a_addr0;
        op_addr[1] = rd_a_addr1;
        op_addr[2] = rd_b_addr0;
        op_addr[3] = rd_b_addr1;
        rf_read_en = 2'b00;
        rf_raddr_0 = '0;
        rf_raddr_1 = '0;
        op_port    = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (op_used[i]) begin
                if (!rf_read_en[0]) begin
                    rf_read_en[0] = 1'b1;
                    rf_raddr_0    = op_addr[i];
                end else begin
                    rf_read_en[1] = 1'b1;
                    rf_raddr_1    = op_addr[i];
                    op_port[i]    = 1'b1;
                end
            end
        end
    end

    // The staged write commits only at the end of this cycle, so forward it
    always_comb begin
        port_data_0 = (rf_write_en && rf_waddr == rf_raddr_0) ? rf_wdata : rf_rdata_0;
        port_data_1 = (rf_write_en && rf_waddr == rf_raddr_1) ? rf_wdata : rf_rdata_1;
        for (int i = 0; i < 4; i++) begin
            op_data[i] = '0;
            if (op_used[i]) begin
                op_data[i] = op_port[i] ? port_data_1 : port_data_0;
            end
        end
        rsp_a_valid_d = gnt_a;
        rsp_b_valid_d = gnt_b;
        rsp_a_data0_d = gnt_a ? op_data[0] : rsp_a_data0_q;
        rsp_a_data1_d = gnt_a ? op_data[1] : rsp_a_data1_q;
        rsp_b_data0_d = gnt_b ? op_data[2] : rsp_b_data0_q;
        rsp_b_data1_d = gnt_b ? op_data[3] : rsp_b_data1_q;
    end

    always_comb begin
        gnt_alu  = !reset && wb_alu_valid && (!wb_mem_valid || wr_ptr_q == SRC_ALU);
        gnt_mem  = !reset && wb_mem_valid && (!wb_alu_valid || wr_ptr_q == SRC_MEM);
        wr_ptr_d = wr_ptr_q;
        if (wb_alu_valid && wb_mem_valid) begin
            wr_ptr_d = gnt_alu ? SRC_MEM : SRC_ALU;
        end
        wen_d   = gnt_alu | gnt_mem;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt_alu) begin
            waddr_d = wb_alu_addr;
            wdata_d = wb_alu_data;
        end else if (gnt_mem) begin
            waddr_d = wb_mem_addr;
            wdata_d = wb_mem_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q      <= LANE_A;
            wr_ptr_q      <= SRC_ALU;
            rsp_a_valid_q <= 1'b0;
            rsp_b_valid_q <= 1'b0;
            rsp_a_data0_q <= '0;
            rsp_a_data1_q <= '0;
            rsp_b_data0_q <= '0;
            rsp_b_data1_q <= '0;
            wen_q         <= 1'b0;
            waddr_q       <= '0;
            wdata_q       <= '0;
        end else begin
            rd_ptr_q      <= rd_ptr_d;
            wr_ptr_q      <= wr_ptr_d;
            rsp_a_valid_q <= rsp_a_valid_d;
            rsp_b_valid_q <= rsp_b_valid_d;
            rsp_a_data0_q <= rsp_a_data0_d;
            rsp_a_data1_q <= rsp_a_data1_d;
            rsp_b_data0_q <= rsp_b_data0_d;
            rsp_b_data1_q <= rsp_b_data1_d;
            wen_q         <= wen_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
        end
    end

    // Pulses are suppressed while reset is held so an in-flight write is dropped
    assign rd_a_ready     = gnt_a;
    assign rd_b_ready     = gnt_b;
    assign wb_alu_ready   = gnt_alu;
    assign wb_mem_ready   = gnt_mem;
    assign rd_a_rsp_valid = rsp_a_valid_q & ~reset;
    assign rd_b_rsp_valid = rsp_b_valid_q & ~reset;
    assign rd_a_rsp_data0 = rsp_a_data0_q;
    assign rd_a_rsp_data1 = rsp_a_data1_q;
    assign rd_b_rsp_data0 = rsp_b_data0_q;
    assign rd_b_rsp_data1 = rsp_b_data1_q;
    assign rf_write_en    = wen_q & ~reset;
    assign rf_waddr       = waddr_q;
    assign rf_wdata       = wdata_q;

endmodule

// File: doc/regfile_port_arbiter.md
Name: regfile_port_arbiter

Overview:
Shares the 64x32 register file's two read ports and single write port between two issue lanes (A, B) and two writeback sources (ALU, MEM). It packs operand reads onto the physical read ports and arbitrates round-robin under contention. It stages writes one cycle and forwards the staged write to same-cycle reads. It sits between the issue/writeback logic and the register_file instance, and drives all of its control pins.

Parameters:
NUM_REGS, 64, number of architectural registers
ADDR_W, 6, register address width (log2 NUM_REGS)
DATA_W, 32, register data width

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
rd_a_valid  in  1  lane A read request valid
rd_a_ready  out  1  lane A request accepted this cycle
rd_a_en  in  2  lane A operand enables [0]=op0, [1]=op1
rd_a_addr0 / rd_a_addr1  in  ADDR_W  lane A operand addresses
rd_a_rsp_valid  out  1  lane A response valid (1-cycle pulse)
rd_a_rsp_data0 / rd_a_rsp_data1  out  DATA_W  lane A operand data
rd_b_*  same set as rd_a_* for lane B
wb_alu_valid / wb_mem_valid  in  1  writeback request valid
wb_alu_ready / wb_mem_ready  out  1  writeback accepted this cycle
wb_alu_addr / wb_mem_addr  in  ADDR_W  destination register
wb_alu_data / wb_mem_data  in  DATA_W  write data
rf_read_en  out  2  to register_file read_en
rf_raddr_0 / rf_raddr_1  out  ADDR_W  to register_file read addresses
rf_rdata_0 / rf_rdata_1  in  DATA_W  from register_file; combinational, same cycle
rf_write_en  out  1  to register_file write_en
rf_waddr  out  ADDR_W  to register_file waddr
rf_wdata  out  DATA_W  to register_file wdata

Behaviour:
- Reset (clk edge with reset=1): all *_ready, *_rsp_valid, rf_read_en, rf_write_en = 0. Response data, rf addresses and rf_wdata = 0. Read RR pointer = A, write RR pointer = ALU. Staged write is cleared, so an in-flight write is dropped.
- Ready outputs are combinational from the valids and the RR pointers, and are forced to 0 while reset=1.
- Read cost per lane = popcount(en). en=00 still consumes a request and produces a response with zero data.
- Read grant:
  - If costA+costB <= 2 with both valid, grant both.
  - Otherwise grant only the lane the pointer favours.
  - A single valid lane is always granted.
- Port packing: granted operands fill rf port 0 first, then port 1. Order is lane A op0, A op1, B op0, B op1. rf_read_en bit k = 1 iff port k is used.
- Read RR pointer flips to the non-granted lane only when a lane was left waiting. It is unchanged otherwise.
- Bypass: if the staged write is active (rf_write_en=1) and a packed read address equals rf_waddr, the captured data is rf_wdata, not rf_rdata.
- Response: read data is captured at the end of the grant cycle. rd_x_rsp_valid pulses for 1 cycle in the next cycle (latency 1). Disabled operands return 0. Data holds until the next response for that lane.
- Write grant:
  - At most one of ALU/MEM is granted per cycle.
  - If both are valid, the write pointer decides, then flips to the loser.
  - If only one is valid, it is granted and the pointer is unchanged.
- Staged write: the granted write is latched and driven on rf_write_en/rf_waddr/rf_wdata for exactly one cycle, the cycle after acceptance. The register file commits it at the end of that cycle.
- Visibility rule:
  - A read sees every write accepted in an earlier cycle (via the RF or via bypass).
  - A write accepted in the same cycle as the read is not visible to that read.
- Same destination from both sources in one cycle: one is accepted per RR, the other stalls. The later-accepted write wins.
- Register 0 has no special treatment.

Test Plan:
1. Reset with all valids high for 2 cycles -> all readies, rsp_valids, rf_read_en, rf_write_en = 0. Then release: lane A and ALU are granted first.
2. ALU writes 0xDEADBEEF to r5 (cycle 0). Lane A reads r5,r5 at cycle 1 -> rf_write_en=1 and rf_waddr=5 at cycle 1. Read is bypassed, and rd_a_rsp_data0 = rd_a_rsp_data1 = 0xDEADBEEF at cycle 2.
3. Lanes A and B both request en=11 for 4 cycles -> grants alternate A,B,A,B, each with rf_read_en=11. Responses arrive 1 cycle after each grant.
4. Lane A en=01 (r3) and lane B en=10 (r7), both valid -> both granted the same cycle with rf_raddr_0=3, rf_raddr_1=7, rf_read_en=11. Both rsp_valids pulse the next cycle.
5. ALU and MEM both write r9 (0x1111 and 0x2222) every cycle -> readies alternate starting with ALU. One rf write per cycle. r9 reads 0x2222 after the MEM write commits.
6. Assert reset while a write is staged and a read response is pending -> the write is not issued (rf_write_en=0), rsp_valid=0, and r-file contents are unchanged.
